// File: rtl/rx_dma_pkt_framer.sv
// rx_dma_pkt_framer: per-packet header insertion, payload forwarding and filter-gated DMA start,
// with tlast timeout recovery, s2mm interrupt coalescing and saturating statistics.
//   clk, rstn                   clock, synchronous active-low reset
//   pkt_start/unsupported/len   packet announcement from the rx path, sampled in IDLE only
//   hdr_words                   HDR_WORDS header words, word 0 in the LSBs
//   filter_valid/block          xpu filter decision
//   pay_data/valid              payload stream, forwarded one register late
//   m_axis_tlast                end of the DMA transfer
//   tsf_pulse_1M, timeout_*     1 us tick and tlast timeout control
//   s2mm_intr, coal_num, dly_top  DMA completion level and coalescing control
//   stat_clr, stat_*            statistics clear and saturating counters
//   start_trans, data_*, num_dma_word, m_axis_rst, tlast_auto_recover  DMA side outputs
//   rx_pkt_sn_plus_one          combinational filter-pass acceptance
//   rx_pkt_intr                 coalesced interrupt pulse to PS
module rx_dma_pkt_framer #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WORDS  = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int SYM_WIDTH  = 14,
    parameter int TO_WIDTH   = 13,
    parameter int COAL_WIDTH = 4,
    parameter int DLY_WIDTH  = 15,
    parameter int STAT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            pkt_start,
    input  logic                            pkt_unsupported,
    input  logic [LEN_WIDTH-1:0]            pkt_len,
    input  logic [HDR_WORDS*DATA_WIDTH-1:0] hdr_words,
    input  logic                            filter_valid,
    input  logic                            filter_block,
    input  logic [DATA_WIDTH-1:0]           pay_data,
    input  logic                            pay_valid,
    input  logic                            m_axis_tlast,
    input  logic                            tsf_pulse_1M,
    input  logic                            timeout_en,
    input  logic [TO_WIDTH-1:0]             timeout_top,
    input  logic                            s2mm_intr,
    input  logic [COAL_WIDTH-1:0]           coal_num,
    input  logic [DLY_WIDTH-1:0]            dly_top,
    input  logic                            stat_clr,
    output logic                            start_trans,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            data_valid_out,
    output logic [SYM_WIDTH-1:0]            num_dma_word,
    output logic                            m_axis_rst,
    output logic                            tlast_auto_recover,
    output logic                            rx_pkt_sn_plus_one,
    output logic                            rx_pkt_intr,
    output logic [STAT_WIDTH-1:0]           stat_pass,
    output logic [STAT_WIDTH-1:0]           stat_block,
    output logic [STAT_WIDTH-1:0]           stat_timeout
);
    localparam int HW = HDR_WORDS > 1 ? $clog2(HDR_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, HDR, WAIT_FILTER, WAIT_TLAST, RST} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hdr_q [HDR_WORDS];
    logic [HW-1:0]         hidx;
    logic [2:0]            rcnt;
    logic [TO_WIDTH-1:0]   tmr;
    logic [LEN_WIDTH:0]    len_words;
    logic [SYM_WIDTH-1:0]  dma_words;
    logic                  waiting, to_hit, pass, block;
    logic                  s2mm_d, rise, fire;
    logic [COAL_WIDTH-1:0] pend, thr;
    logic [DLY_WIDTH-1:0]  dly;

    // one extra bit so the round-up cannot overflow at the top of the length range
    assign len_words = ({1'b0, pkt_len} + (LEN_WIDTH+1)'(7)) >> 3;
    assign dma_words = SYM_WIDTH'(len_words + (LEN_WIDTH+1)'(HDR_WORDS));
    assign waiting   = (state == WAIT_FILTER) || (state == WAIT_TLAST);
    assign to_hit    = waiting && timeout_en && (tmr > timeout_top);
    assign pass      = (state == WAIT_FILTER) && filter_valid && !filter_block && !to_hit;
    assign block     = (state == WAIT_FILTER) && filter_valid && filter_block && !to_hit;
    assign rx_pkt_sn_plus_one = pass;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state              <= IDLE;
            hidx               <= '0;
            rcnt               <= '0;
            tmr                <= '0;
            start_trans        <= 1'b0;
            data_out           <= '0;
            data_valid_out     <= 1'b0;
            num_dma_word       <= '0;
            m_axis_rst         <= 1'b0;
            tlast_auto_recover <= 1'b0;
            for (int i = 0; i < HDR_WORDS; i++) hdr_q[i] <= '0;
        end else begin
            start_trans        <= 1'b0;
            tlast_auto_recover <= 1'b0;
            case (state)
                IDLE: begin
                    data_valid_out <= 1'b0;
                    tmr            <= '0;
                    if (pkt_start && !pkt_unsupported) begin
                        for (int i = 0; i < HDR_WORDS; i++) hdr_q[i] <= hdr_words[i*DATA_WIDTH +: DATA_WIDTH];
                        num_dma_word <= dma_words;
                        hidx         <= '0;
                        state        <= HDR;
                    end
                end
                HDR: begin
                    data_out       <= hdr_q[hidx];
                    data_valid_out <= 1'b1;
                    hidx           <= hidx + 1'b1;
                    if (hidx == HW'(HDR_WORDS-1)) state <= WAIT_FILTER;
                end
                WAIT_FILTER, WAIT_TLAST: begin
                    data_out       <= pay_data;
                    data_valid_out <= pay_valid;
                    if (tsf_pulse_1M) tmr <= tmr + 1'b1;
                    // timeout wins over a filter decision or tlast arriving in the same cycle
                    if (to_hit) begin
                        m_axis_rst         <= 1'b1;
                        tlast_auto_recover <= 1'b1;
                        rcnt               <= '0;
                        state              <= RST;
                    end else if (pass) begin
                        tmr         <= '0;
                        start_trans <= 1'b1;
                        state       <= WAIT_TLAST;
                    end else if (block) begin
                        m_axis_rst <= 1'b1;
                        rcnt       <= '0;
                        state      <= RST;
                    end else if (state == WAIT_TLAST && m_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                RST: begin
                    data_valid_out <= 1'b0;
                    num_dma_word   <= '0;
                    rcnt           <= rcnt + 3'd1;
                    // m_axis_rst was raised on entry, so it stays high for exactly 8 cycles
                    if (rcnt == 3'd7) begin
                        m_axis_rst <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v, input logic en);
        return (en && !(&v)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn || stat_clr) begin
            stat_pass    <= '0;
            stat_block   <= '0;
            stat_timeout <= '0;
        end else begin
            stat_pass    <= sat_inc(stat_pass, pass);
            stat_block   <= sat_inc(stat_block, block);
            stat_timeout <= sat_inc(stat_timeout, to_hit);
        end
    end

    assign rise = s2mm_intr && !s2mm_d;
    assign thr  = (coal_num == '0) ? COAL_WIDTH'(1) : coal_num;
    assign fire = (pend != '0) && ((pend >= thr) || (dly == dly_top));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2mm_d      <= 1'b0;
            pend        <= '0;
            dly         <= '0;
            rx_pkt_intr <= 1'b0;
        end else begin
            s2mm_d      <= s2mm_intr;
            rx_pkt_intr <= fire;
            if (fire) begin
                // a completion arriving as we fire opens the next batch
                pend <= rise ? COAL_WIDTH'(1) : '0;
                dly  <= '0;
            end else begin
                if (rise && !(&pend)) pend <= pend + 1'b1;
                if (pend != '0) dly <= dly + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rx_dma_pkt_framer.sv
// tb_rx_dma_pkt_framer: scoreboard bench for rx_dma_pkt_framer (statistics narrowed to 4 bits for saturation).
module tb_rx_dma_pkt_framer;
    localparam int DW = 64, HW = 4, LW = 16, SW = 14, TW = 13, CW = 4, YW = 15, STW = 4;

    logic clk = 0, rstn = 0;
    logic pkt_start = 0, pkt_unsupported = 0;
    logic [LW-1:0] pkt_len = '0;
    logic [HW*DW-1:0] hdr_words = '0;
    logic filter_valid = 0, filter_block = 0;
    logic [DW-1:0] pay_data = '0;
    logic pay_valid = 0, m_axis_tlast = 0, tsf_pulse_1M = 0, timeout_en = 0;
    logic [TW-1:0] timeout_top = '0;
    logic s2mm_intr = 0;
    logic [CW-1:0] coal_num = '0;
    logic [YW-1:0] dly_top = '0;
    logic stat_clr = 0;
    logic start_trans, data_valid_out, m_axis_rst, tlast_auto_recover, rx_pkt_sn_plus_one, rx_pkt_intr;
    logic [DW-1:0] data_out;
    logic [SW-1:0] num_dma_word;
    logic [STW-1:0] stat_pass, stat_block, stat_timeout;

    rx_dma_pkt_framer #(
        .DATA_WIDTH(DW), .HDR_WORDS(HW), .LEN_WIDTH(LW), .SYM_WIDTH(SW), .TO_WIDTH(TW),
        .COAL_WIDTH(CW), .DLY_WIDTH(YW), .STAT_WIDTH(STW)
    ) dut (
        .clk(clk), .rstn(rstn), .pkt_start(pkt_start), .pkt_unsupported(pkt_unsupported),
        .pkt_len(pkt_len), .hdr_words(hdr_words), .filter_valid(filter_valid), .filter_block(filter_block),
        .pay_data(pay_data), .pay_valid(pay_valid), .m_axis_tlast(m_axis_tlast), .tsf_pulse_1M(tsf_pulse_1M),
        .timeout_en(timeout_en), .timeout_top(timeout_top), .s2mm_intr(s2mm_intr), .coal_num(coal_num),
        .dly_top(dly_top), .stat_clr(stat_clr), .start_trans(start_trans), .data_out(data_out),
        .data_valid_out(data_valid_out), .num_dma_word(num_dma_word), .m_axis_rst(m_axis_rst),
        .tlast_auto_recover(tlast_auto_recover), .rx_pkt_sn_plus_one(rx_pkt_sn_plus_one),
        .rx_pkt_intr(rx_pkt_intr), .stat_pass(stat_pass), .stat_block(stat_block), .stat_timeout(stat_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0, n_start = 0, n_rec = 0;
    logic [DW-1:0] exp_data [$];
    int exp_intr [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid_out) begin
            chk("word_expected", 64'(exp_data.size() != 0), 1);
            if (exp_data.size() != 0) chk("data_out", data_out, exp_data.pop_front());
        end
        if (rx_pkt_intr) begin
            chk("intr_expected", 64'(exp_intr.size() != 0), 1);
            if (exp_intr.size() != 0) chk("intr_cycle", 64'(cyc), 64'(exp_intr.pop_front()));
        end
        if (start_trans) n_start++;
        if (tlast_auto_recover) n_rec++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Announce a packet, check header timing/contiguity, then feed npay payload words in WAIT_FILTER.
    task automatic send_pkt(input int len, input int npay);
        logic [HW*DW-1:0] h;
        for (int i = 0; i < HW; i++) h[i*DW +: DW] = {$urandom, $urandom};
        for (int i = 0; i < HW; i++) exp_data.push_back(h[i*DW +: DW]);
        hdr_words = h; pkt_len = LW'(len); pkt_unsupported = 0; pkt_start = 1;
        step();
        pkt_start = 0; hdr_words = ~h;
        chk("hdr_not_yet", 64'(data_valid_out), 0);
        step();
        chk("hdr_first", 64'(data_valid_out), 1);
        chk("hdr_word0", data_out, h[DW-1:0]);
        chk("num_dma_word", 64'(num_dma_word), 64'(((len + 7) / 8 + HW) % (1 << SW)));
        for (int k = 1; k < HW; k++) begin
            step();
            chk("hdr_contig", 64'(data_valid_out), 1);
        end
        step();
        for (int i = 0; i < npay; i++) begin
            pay_data = {$urandom, $urandom}; pay_valid = 1;
            exp_data.push_back(pay_data);
            step();
        end
        pay_valid = 0;
    endtask

    task automatic filter(input logic blk, input logic exp_sn);
        filter_valid = 1; filter_block = blk;
        #1 chk("sn_plus_one", 64'(rx_pkt_sn_plus_one), 64'(exp_sn));
        step();
        filter_valid = 0; filter_block = 0;
    endtask

    task automatic tlast();
        m_axis_tlast = 1;
        step();
        m_axis_tlast = 0;
        step();
    endtask

    task automatic s2mm_edge(input int lat);
        if (lat > 0) exp_intr.push_back(cyc + lat);
        s2mm_intr = 1;
        step(2);
        s2mm_intr = 0;
    endtask

    task automatic drain_intr(input int budget);
        for (int i = 0; i < budget && exp_intr.size() != 0; i++) step();
        chk("intr_drained", 64'(exp_intr.size()), 0);
    endtask

    initial begin
        int s0, r0, hi;
        step(3);
        chk("rst_start", 64'(start_trans), 0);
        chk("rst_valid", 64'(data_valid_out), 0);
        chk("rst_data", data_out, 0);
        chk("rst_words", 64'(num_dma_word), 0);
        chk("rst_mrst", 64'(m_axis_rst), 0);
        chk("rst_intr", 64'(rx_pkt_intr), 0);
        chk("rst_stats", {stat_pass, stat_block, stat_timeout}, 0);
        rstn = 1;
        step();

        // filter pass, then a pkt_start in WAIT_TLAST that must be ignored
        s0 = n_start;
        send_pkt(100, 3);
        step(2);
        filter(0, 1);
        chk("pass_start", 64'(start_trans), 1);
        chk("pass_stat", 64'(stat_pass), 1);
        chk("pass_words", 64'(num_dma_word), 17);
        step();
        chk("start_one_cycle", 64'(start_trans), 0);
        pkt_len = 800; hdr_words = {HW{64'hdead}}; pkt_start = 1;
        step();
        pkt_start = 0;
        step(8);
        chk("busy_ignore_words", 64'(num_dma_word), 17);
        tlast();
        chk("pass_start_count", 64'(n_start - s0), 1);

        // filter block
        s0 = n_start;
        send_pkt(64, 2);
        step(3);
        filter(1, 0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_rst) hi++;
            step();
        end
        chk("block_rst_len", 64'(hi), 8);
        chk("block_stat", 64'(stat_block), 1);
        chk("block_pass_stat", 64'(stat_pass), 1);
        chk("block_no_start", 64'(n_start - s0), 0);
        chk("block_words", 64'(num_dma_word), 0);

        // tlast timeout, with a simultaneous filter pass losing to it
        r0 = n_rec; s0 = n_start;
        timeout_top = 3; timeout_en = 1;
        send_pkt(40, 0);
        for (int i = 0; i < 3; i++) begin
            tsf_pulse_1M = 1; step(); tsf_pulse_1M = 0; step(4);
        end
        chk("to_early", 64'(n_rec - r0), 0);
        chk("to_early_rst", 64'(m_axis_rst), 0);
        tsf_pulse_1M = 1; step(); tsf_pulse_1M = 0;
        filter_valid = 1; filter_block = 0;
        #1 chk("to_prio_sn", 64'(rx_pkt_sn_plus_one), 0);
        step();
        filter_valid = 0;
        chk("to_recover", 64'(tlast_auto_recover), 1);
        chk("to_mrst", 64'(m_axis_rst), 1);
        chk("to_stat", 64'(stat_timeout), 1);
        chk("to_prio_pass", 64'(stat_pass), 1);
        step();
        chk("to_recover_pulse", 64'(tlast_auto_recover), 0);
        step(10);
        chk("to_no_start", 64'(n_start - s0), 0);

        // timeout disabled: the packet waits through many ticks
        r0 = n_rec;
        timeout_en = 0;
        send_pkt(40, 0);
        for (int i = 0; i < 10; i++) begin
            tsf_pulse_1M = 1; step(); tsf_pulse_1M = 0; step(2);
        end
        chk("noto_recover", 64'(n_rec - r0), 0);
        chk("noto_mrst", 64'(m_axis_rst), 0);
        filter(0, 1);
        step();
        tlast();
        chk("noto_pass_stat", 64'(stat_pass), 2);

        // unsupported packet
        pkt_unsupported = 1; pkt_len = 500; pkt_start = 1;
        step();
        pkt_start = 0; pkt_unsupported = 0;
        step(8);
        chk("unsup_words", 64'(num_dma_word), 9);
        chk("unsup_stats", {stat_pass, stat_block, stat_timeout}, {4'd2, 4'd1, 4'd1});

        // interrupt coalescing: count, delay, and coal_num 0
        coal_num = 3; dly_top = 1000;
        s2mm_edge(0); step(48);
        s2mm_edge(0); step(48);
        s2mm_edge(2);
        drain_intr(50);
        step(5);
        s2mm_edge(1002);
        drain_intr(1100);
        step(5);
        coal_num = 0;
        s2mm_edge(2); step(8);
        s2mm_edge(2);
        drain_intr(50);

        // reset in WAIT_TLAST
        send_pkt(100, 2);
        step(2);
        filter(0, 1);
        step();
        rstn = 0;
        step();
        chk("mid_rst_valid", 64'(data_valid_out), 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_words", 64'(num_dma_word), 0);
        chk("mid_rst_start", 64'(start_trans), 0);
        chk("mid_rst_mrst", 64'(m_axis_rst), 0);
        chk("mid_rst_stats", {stat_pass, stat_block, stat_timeout}, 0);
        rstn = 1;
        step();

        // saturation of a narrowed counter, then clear
        for (int p = 0; p < 16; p++) begin
            send_pkt(8, 0);
            filter(0, 1);
            step();
            tlast();
            if (p == 14) chk("sat_before", 64'(stat_pass), 15);
        end
        chk("sat_hold", 64'(stat_pass), 15);
        stat_clr = 1;
        step();
        stat_clr = 0;
        chk("stat_clr", {stat_pass, stat_block, stat_timeout}, 0);

        step(3);
        chk("data_drained", 64'(exp_data.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
